combo_lock_seq: RTL

COMBO_LOCK_SEQ -- requirements
Module: combo_lock_seq

---
 rtl/combo_lock_pkg.sv | 22 ++
 rtl/lock_timer.sv | 28 ++
 rtl/combo_lock_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/combo_lock_pkg.sv
// Shared types and default constants for the combination-lock sequencer.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_OPEN,
    ST_LOCKOUT
  } state_e;

  localparam int          CODE_W_DEF         = 16;
  localparam int          SEQ_LEN_DEF        = 2;
  localparam int          MAX_TRIES_DEF      = 3;
  localparam int          OPEN_CYCLES_DEF    = 4;
  localparam int          LOCKOUT_CYCLES_DEF = 8;
  localparam logic [31:0] DEFAULT_CODE_DEF   = {16'hDF6F, 16'hD6FF};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done_o is high while the count is zero.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         count_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/combo_lock_seq.sv
// Sequential combination lock with try counting and timed open/lockout windows.
// Define COMBO_LOCK_PROG_EN to add the prog_* ports for rewriting the code while open.
module combo_lock_seq
  import combo_lock_pkg::*;
#(
  parameter int                          CODE_W         = CODE_W_DEF,
  parameter int                          SEQ_LEN        = SEQ_LEN_DEF,
  parameter int                          MAX_TRIES      = MAX_TRIES_DEF,
  parameter int                          OPEN_CYCLES    = OPEN_CYCLES_DEF,
  parameter int                          LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
  parameter logic [SEQ_LEN*CODE_W-1:0]   DEFAULT_CODE   = DEFAULT_CODE_DEF
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [CODE_W-1:0]                            x,
  input  logic                                         x_valid,
`ifdef COMBO_LOCK_PROG_EN
  input  logic                                         prog_we,
  input  logic [((SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1)-1:0] prog_idx,
  input  logic [CODE_W-1:0]                            prog_data,
`endif
  output logic                                         z,
  output logic [$clog2(MAX_TRIES+1)-1:0]               try,
  output logic                                         reset_try,
  output logic                                         locked_out
);

  localparam int IDX_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int NWORDS = 1 << IDX_W;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int TMR_W  = $clog2(max_int(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEQ_LEN - 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] OPEN_LD   = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LD   = TMR_W'(LOCKOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TRY_W-1:0]   try_q, try_d, try_inc;
  logic               z_q, locked_out_q, reset_try_q, reset_try_d;
  logic               tmr_load, tmr_done, tmr_count;
  logic [TMR_W-1:0]   tmr_val;
  logic [CODE_W-1:0]  code_w [NWORDS];

  // Power-of-two sized store so idx never selects outside the array.
`ifdef COMBO_LOCK_PROG_EN
  logic [CODE_W-1:0] code_q [NWORDS];

  // NOTE: the code store is a handful of flops, so it is reset to the default code rather than left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) begin
        code_q[i] <= (i < SEQ_LEN) ? DEFAULT_CODE[(SEQ_LEN-i)*CODE_W-1 -: CODE_W] : '0;
      end
    end else if ((state_q == ST_OPEN) && prog_we && (int'(prog_idx) < SEQ_LEN)) begin
      code_q[prog_idx] <= prog_data;
    end
  end

  assign code_w = code_q;
`else
  for (genvar g = 0; g < NWORDS; g++) begin : g_code
    if (g < SEQ_LEN) begin : g_word
      assign code_w[g] = DEFAULT_CODE[(SEQ_LEN-g)*CODE_W-1 -: CODE_W];
    end else begin : g_pad
      assign code_w[g] = '0;
    end
  end
`endif

  assign try_inc   = try_q + 1'b1;
  assign tmr_count = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    try_d       = try_q;
    reset_try_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (x_valid) begin
          if (x == code_w[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d  = ST_OPEN;
              idx_d    = '0;
              try_d    = '0;
              tmr_load = 1'b1;
              tmr_val  = OPEN_LD;
            end else begin
              state_d = ST_ENTRY;
              idx_d   = idx_q + 1'b1;
            end
          end else begin
            idx_d = '0;
            try_d = try_inc;
            if (try_inc == TRY_LIMIT) begin
              state_d  = ST_LOCKOUT;
              tmr_load = 1'b1;
              tmr_val  = LOCK_LD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_OPEN: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d     = ST_IDLE;
          try_d       = '0;
          reset_try_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      try_q        <= '0;
      z_q          <= 1'b0;
      locked_out_q <= 1'b0;
      reset_try_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      try_q        <= try_d;
      z_q          <= (state_d == ST_OPEN);
      locked_out_q <= (state_d == ST_LOCKOUT);
      reset_try_q  <= reset_try_d;
    end
  end

  lock_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_i    (tmr_count),
    .done_o     (tmr_done)
  );

  assign z          = z_q;
  assign try        = try_q;
  assign reset_try  = reset_try_q;
  assign locked_out = locked_out_q;

endmodule
